// File: rtl/decode_cycle.sv
// RV32I decode stage: control/ALU decode, immediate extension, 32x32 register file and ID/EX register.
// Macro REGFILE_BYPASS_EN selects write-first register reads; undefined gives read-first.
module decode_cycle (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_d,
   input  logic [31:0] pc_d,
   input  logic [31:0] pcplus4_d,
   input  logic        flush_e,
   input  logic        regwrite_w,
   input  logic [4:0]  rd_w,
   input  logic [31:0] result_w,
   output logic        regwrite_e,
   output logic        memwrite_e,
   output logic        jump_e,
   output logic        branch_e,
   output logic        alusrc_e,
   output logic [1:0]  resultsrc_e,
   output logic [2:0]  alucontrol_e,
   output logic [31:0] rd1_e,
   output logic [31:0] rd2_e,
   output logic [31:0] imm_ext_e,
   output logic [31:0] pc_e,
   output logic [31:0] pcplus4_e,
   output logic [4:0]  rs1_e,
   output logic [4:0]  rs2_e,
   output logic [4:0]  rd_e,
   output logic [4:0]  rs1_d,
   output logic [4:0]  rs2_d,
   output logic        illegal_e
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic [4:0]  rd_d;

   logic        regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d, illegal_d;
   logic [1:0]  resultsrc_d;
   logic [2:0]  alucontrol_d;
   logic        alu_by_funct;
   imm_src_t    immsrc_d;
   logic [31:0] imm_ext_d;
   logic [31:0] rd1_d, rd2_d;

   logic [31:0] regs [32];

   assign opcode   = instr_d[6:0];
   assign funct3   = instr_d[14:12];
   assign funct7_5 = instr_d[30];
   assign rd_d     = instr_d[11:7];
   assign rs1_d    = instr_d[19:15];
   assign rs2_d    = instr_d[24:20];

   always_comb begin
      regwrite_d   = 1'b0;
      memwrite_d   = 1'b0;
      jump_d       = 1'b0;
      branch_d     = 1'b0;
      alusrc_d     = 1'b0;
      illegal_d    = 1'b0;
      resultsrc_d  = 2'b00;
      alu_by_funct = 1'b0;
      immsrc_d     = IMM_I;
      case (opcode)
         OP_LW: begin
            regwrite_d  = 1'b1;
            alusrc_d    = 1'b1;
            resultsrc_d = 2'b01;
         end
         OP_SW: begin
            memwrite_d = 1'b1;
            alusrc_d   = 1'b1;
            immsrc_d   = IMM_S;
         end
         OP_R: begin
            regwrite_d   = 1'b1;
            alu_by_funct = 1'b1;
         end
         OP_IALU: begin
            regwrite_d   = 1'b1;
            alusrc_d     = 1'b1;
            alu_by_funct = 1'b1;
         end
         OP_BEQ: begin
            branch_d = 1'b1;
            immsrc_d = IMM_B;
         end
         OP_JAL: begin
            regwrite_d  = 1'b1;
            jump_d      = 1'b1;
            resultsrc_d = 2'b10;
            immsrc_d    = IMM_J;
         end
         default: illegal_d = 1'b1;
      endcase
   end

   // Only register-register ops can subtract on funct3=000; addi with imm bit 30 set stays add.
   always_comb begin
      alucontrol_d = 3'b000;
      if (opcode == OP_BEQ) begin
         alucontrol_d = 3'b001;
      end else if (alu_by_funct) begin
         case (funct3)
            3'b000:  alucontrol_d = (opcode == OP_R && funct7_5) ? 3'b001 : 3'b000;
            3'b010:  alucontrol_d = 3'b101;
            3'b110:  alucontrol_d = 3'b011;
            3'b111:  alucontrol_d = 3'b010;
            default: alucontrol_d = 3'b000;
         endcase
      end
   end

   always_comb begin
      imm_ext_d = '0;
      case (immsrc_d)
         IMM_I: imm_ext_d = {{20{instr_d[31]}}, instr_d[31:20]};
         IMM_S: imm_ext_d = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
         IMM_B: imm_ext_d = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
         IMM_J: imm_ext_d = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
         default: imm_ext_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (regwrite_w && rd_w != 5'd0) begin
         regs[rd_w] <= result_w;
      end
   end

`ifdef REGFILE_BYPASS_EN
   always_comb begin
      rd1_d = '0;
      rd2_d = '0;
      if (rs1_d != 5'd0)
         rd1_d = (regwrite_w && rd_w == rs1_d) ? result_w : regs[rs1_d];
      if (rs2_d != 5'd0)
         rd2_d = (regwrite_w && rd_w == rs2_d) ? result_w : regs[rs2_d];
   end
`else
   always_comb begin
      rd1_d = '0;
      rd2_d = '0;
      if (rs1_d != 5'd0) rd1_d = regs[rs1_d];
      if (rs2_d != 5'd0) rd2_d = regs[rs2_d];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst || flush_e) begin
         regwrite_e   <= 1'b0;
         memwrite_e   <= 1'b0;
         jump_e       <= 1'b0;
         branch_e     <= 1'b0;
         alusrc_e     <= 1'b0;
         resultsrc_e  <= 2'b00;
         alucontrol_e <= 3'b000;
         rd1_e        <= '0;
         rd2_e        <= '0;
         imm_ext_e    <= '0;
         pc_e         <= '0;
         pcplus4_e    <= '0;
         rs1_e        <= '0;
         rs2_e        <= '0;
         rd_e         <= '0;
         illegal_e    <= 1'b0;
      end else begin
         regwrite_e   <= regwrite_d;
         memwrite_e   <= memwrite_d;
         jump_e       <= jump_d;
         branch_e     <= branch_d;
         alusrc_e     <= alusrc_d;
         resultsrc_e  <= resultsrc_d;
         alucontrol_e <= alucontrol_d;
         rd1_e        <= rd1_d;
         rd2_e        <= rd2_d;
         imm_ext_e    <= imm_ext_d;
         pc_e         <= pc_d;
         pcplus4_e    <= pcplus4_d;
         rs1_e        <= rs1_d;
         rs2_e        <= rs2_d;
         rd_e         <= rd_d;
         illegal_e    <= illegal_d;
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed cases plus randomized traffic against a reference model.
module tb_decode_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_d, pc_d, pcplus4_d;
   logic        flush_e, regwrite_w;
   logic [4:0]  rd_w;
   logic [31:0] result_w;
   logic        regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e, illegal_e;
   logic [1:0]  resultsrc_e;
   logic [2:0]  alucontrol_e;
   logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e;
   logic [4:0]  rs1_e, rs2_e, rd_e, rs1_d, rs2_d;

   int checks = 0;
   int errors = 0;

   logic [31:0]  model_regs [32];
   logic [185:0] exp_vec;
   logic [185:0] got_vec;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   decode_cycle dut (
      .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
      .flush_e(flush_e), .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
      .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .jump_e(jump_e), .branch_e(branch_e),
      .alusrc_e(alusrc_e), .resultsrc_e(resultsrc_e), .alucontrol_e(alucontrol_e),
      .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .illegal_e(illegal_e)
   );

   always #5 clk = ~clk;

   assign got_vec = {regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e, resultsrc_e,
                     alucontrol_e, rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e,
                     rs1_e, rs2_e, rd_e, illegal_e};

   function automatic logic [31:0] ref_read(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (BYPASS && !rst && regwrite_w && rd_w == a) return result_w;
      return model_regs[a];
   endfunction

   // Expected ID/EX contents from the instruction-set rules for the current inputs.
   function automatic logic [185:0] ref_decode();
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] imm;
      logic        rw, mw, jp, br, as, ill;
      logic [1:0]  rs;
      logic [2:0]  alu;
      op = instr_d[6:0];
      f3 = instr_d[14:12];
      {rw, mw, jp, br, as, ill} = 6'b0;
      rs  = 2'b00;
      alu = 3'd0;
      imm = 32'($signed(instr_d[31:20]));
      case (op)
         7'h03: begin rw = 1; as = 1; rs = 2'b01; end
         7'h23: begin mw = 1; as = 1; imm = 32'($signed({instr_d[31:25], instr_d[11:7]})); end
         7'h33, 7'h13: begin
            rw = 1;
            as = (op == 7'h13);
            if (f3 == 3'd2) alu = 3'd5;
            else if (f3 == 3'd6) alu = 3'd3;
            else if (f3 == 3'd7) alu = 3'd2;
            else if (f3 == 3'd0 && op == 7'h33 && instr_d[30]) alu = 3'd1;
         end
         7'h63: begin
            br = 1; alu = 3'd1;
            imm = 32'($signed({instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0}));
         end
         7'h6F: begin
            rw = 1; jp = 1; rs = 2'b10;
            imm = 32'($signed({instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0}));
         end
         default: ill = 1;
      endcase
      if (rst || flush_e) return '0;
      return {rw, mw, jp, br, as, rs, alu, ref_read(instr_d[19:15]), ref_read(instr_d[24:20]),
              imm, pc_d, pcplus4_d, instr_d[19:15], instr_d[24:20], instr_d[11:7], ill};
   endfunction

   // Compute expectation, take one edge, update model storage, settle past the edge.
   task automatic step();
      logic        w_en;
      logic [4:0]  w_a;
      logic [31:0] w_d;
      logic        r;
      exp_vec = ref_decode();
      r = rst; w_en = regwrite_w; w_a = rd_w; w_d = result_w;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model_regs[i] = '0;
      end else if (w_en && w_a != 0) begin
         model_regs[w_a] = w_d;
      end
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      instr_d = ins; pc_d = pc; pcplus4_d = pc + 32'd4;
   endtask

   task automatic test_reset();
      rst = 1; flush_e = 0;
      drive(32'h00500093, 32'h40);
      regwrite_w = 1; rd_w = 5; result_w = 32'hAA;
      step();
      step();
      checks++;
      if (got_vec !== '0) begin
         errors++; $display("FAIL reset_outputs got %h want 0", got_vec);
      end
      rst = 0; regwrite_w = 0;
      for (int i = 0; i < 32; i++) begin
         drive({7'd0, 5'd0, i[4:0], 3'd0, 5'd3, 7'h33}, 32'h0);
         step();
         checks++;
         if (rd1_e !== 32'd0) begin
            errors++; $display("FAIL reset_reg x%0d got %h want 0", i, rd1_e);
         end
      end
   endtask

   task automatic test_decode();
      drive(32'h00500093, 32'h100);
      step();
      checks++;
      if (got_vec !== exp_vec || regwrite_e !== 1 || alusrc_e !== 1 || alucontrol_e !== 3'b000 ||
          imm_ext_e !== 32'd5 || rd_e !== 5'd1 || rs1_e !== 5'd0 ||
          pc_e !== 32'h100 || pcplus4_e !== 32'h104) begin
         errors++; $display("FAIL addi got %h want %h", got_vec, exp_vec);
      end
      drive(32'h0080A103, 32'h104); step();
      checks++;
      if (got_vec !== exp_vec || resultsrc_e !== 2'b01 || imm_ext_e !== 32'd8) begin
         errors++; $display("FAIL lw got %h want %h", got_vec, exp_vec);
      end
      drive(32'h0020A623, 32'h108); step();
      checks++;
      if (got_vec !== exp_vec || memwrite_e !== 1 || regwrite_e !== 0 || imm_ext_e !== 32'd12) begin
         errors++; $display("FAIL sw got %h want %h", got_vec, exp_vec);
      end
      drive(32'hFE208EE3, 32'h10C); step();
      checks++;
      if (got_vec !== exp_vec || branch_e !== 1 || alucontrol_e !== 3'b001 ||
          imm_ext_e !== 32'hFFFFFFFC) begin
         errors++; $display("FAIL beq got %h want %h", got_vec, exp_vec);
      end
      drive(32'h008000EF, 32'h110); step();
      checks++;
      if (got_vec !== exp_vec || jump_e !== 1 || resultsrc_e !== 2'b10 || imm_ext_e !== 32'd8) begin
         errors++; $display("FAIL jal got %h want %h", got_vec, exp_vec);
      end
      drive(32'h402081B3, 32'h114); step();
      checks++;
      if (got_vec !== exp_vec || alucontrol_e !== 3'b001) begin
         errors++; $display("FAIL sub got %h want %h", got_vec, exp_vec);
      end
      drive(32'h0000007F, 32'h118); step();
      checks++;
      if (illegal_e !== 1 || {regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e,
                              resultsrc_e, alucontrol_e} !== 10'd0) begin
         errors++; $display("FAIL illegal got %h want ctrl 0 illegal 1", got_vec);
      end
   endtask

   task automatic test_writeback();
      drive(32'h001081B3, 32'h200);
      regwrite_w = 1; rd_w = 1; result_w = 32'h55;
      step();
      checks++;
      if (rd1_e !== (BYPASS ? 32'h55 : 32'h0) || rd2_e !== (BYPASS ? 32'h55 : 32'h0)) begin
         errors++; $display("FAIL wb_same_cycle got %h/%h want %h", rd1_e, rd2_e,
                            BYPASS ? 32'h55 : 32'h0);
      end
      regwrite_w = 0;
      step();
      checks++;
      if (rd1_e !== 32'h55 || rd2_e !== 32'h55) begin
         errors++; $display("FAIL wb_next_cycle got %h/%h want 55", rd1_e, rd2_e);
      end
      drive(32'h000001B3, 32'h208);
      regwrite_w = 1; rd_w = 0; result_w = 32'hFF;
      step();
      regwrite_w = 0;
      step();
      checks++;
      if (rd1_e !== 32'h0 || rd2_e !== 32'h0) begin
         errors++; $display("FAIL x0_write got %h/%h want 0", rd1_e, rd2_e);
      end
   endtask

   task automatic test_flush();
      drive(32'h0020A623, 32'h300);
      flush_e = 1; regwrite_w = 1; rd_w = 4; result_w = 32'h99;
      step();
      checks++;
      if (got_vec !== '0 || memwrite_e !== 0) begin
         errors++; $display("FAIL flush got %h want 0", got_vec);
      end
      flush_e = 0; regwrite_w = 0;
      drive(32'h004201B3, 32'h304);
      step();
      checks++;
      if (rd1_e !== 32'h99 || rd2_e !== 32'h99) begin
         errors++; $display("FAIL flush_wb got %h/%h want 99", rd1_e, rd2_e);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [8];
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00, 7'h00};
      for (int n = 0; n < 400; n++) begin
         logic [31:0] ins;
         int k;
         ins = $urandom;
         k = $urandom_range(0, 7);
         if (k < 6) ins[6:0] = ops[k];
         else ins[6:0] = 7'($urandom);
         drive(ins, $urandom);
         flush_e    = ($urandom_range(0, 9) == 0);
         regwrite_w = $urandom_range(0, 1);
         rd_w       = ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom);
         result_w   = $urandom;
         #1;
         checks++;
         if (rs1_d !== ins[19:15] || rs2_d !== ins[24:20]) begin
            errors++; $display("FAIL rs_d got %h/%h want %h/%h", rs1_d, rs2_d, ins[19:15], ins[24:20]);
         end
         step();
         checks++;
         if (got_vec !== exp_vec) begin
            errors++; $display("FAIL random[%0d] instr %h got %h want %h", n, ins, got_vec, exp_vec);
         end
      end
      flush_e = 0; regwrite_w = 0;
   endtask

   initial begin
      rst = 1; flush_e = 0; regwrite_w = 0; rd_w = 0; result_w = 0;
      instr_d = 0; pc_d = 0; pcplus4_d = 0;
      for (int i = 0; i < 32; i++) model_regs[i] = 'x;
      #2;
      test_reset();
      test_decode();
      test_writeback();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
